uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
Configurable UART frame transmitter. It serialises one data word per handshake onto the TX line, using the same runtime frame configuration (parity, data bits, stop bits, baud select) that the board's switch configuration register supplies to the receive path. The receive path's start/parity/stop checks validate the frames this block produces. Upstream it is fed by the TX FIFO; downstream it drives the serial pin directly.

Parameters:
DBITS, 8, maximum data width; 7-bit mode uses bits [6:0].
BAUD_DIV0, 5208, clock cycles per bit when i_bd_rate=00 (9600 baud at 50 MHz).
BAUD_DIV1, 2604, cycles per bit when i_bd_rate=01 (19200 baud).
BAUD_DIV2, 868, cycles per bit when i_bd_rate=10 (57600 baud).
BAUD_DIV3, 434, cycles per bit when i_bd_rate=11 (115200 baud).
All BAUD_DIVn values must be in the range 2..65535; a 16-bit bit-timer is used.

Ports:
i_clk  in  1  clock; single clock domain.
i_rst  in  1  synchronous, active-high reset.
i_valid  in  1  word available from the TX FIFO.
o_ready  out  1  block accepts a word; high only in IDLE.
i_data  in  DBITS  word to send, LSB first.
i_par  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
i_d_num  in  1  data bits: 0 = 7, 1 = 8.
i_s_num  in  1  stop bits: 0 = 1, 1 = 2.
i_bd_rate  in  2  selects BAUD_DIV0..3.
o_tx  out  1  serial line, idle high, registered.
o_busy  out  1  frame in progress (any state other than IDLE).
o_tx_done  out  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Reset, on the clock edge with i_rst=1, puts the block in IDLE with o_tx=1, o_ready=1, o_busy=0, o_tx_done=0, and clears the bit timer, bit counter and shift register. Reset overrides every other input, including mid-frame: o_tx returns high at that edge.
- Handshake: a word is accepted on an edge where i_valid=1 and o_ready=1.
  - At acceptance, latch i_data, i_par, i_d_num, i_s_num and the divisor selected by i_bd_rate.
  - Configuration changes during a frame have no effect until the next acceptance.
- i_valid while busy is ignored; no data is consumed.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance. o_tx=0 from the cycle after acceptance (one-cycle latency).
  - Every state except IDLE holds its bit for exactly DIV cycles; the timer counts 0..DIV-1.
  - START -> DATA.
  - DATA shifts out N bits, LSB first, with N = 8 if d_num else 7. After bit N-1, go to PARITY if parity is enabled, else to STOP.
  - PARITY sends XOR of the N data bits for even mode, and its inverse for odd mode. It then goes to STOP.
  - STOP holds o_tx=1 for 1 or 2 bit periods according to s_num, then returns to IDLE.
- o_tx_done pulses high in the first IDLE cycle after the frame. o_ready is also high in that cycle, so a back-to-back word can be accepted there.
  - Minimum gap between frames: stop-bit time plus one clock.
- Frame length: (1 + N + P + S) × DIV cycles, where P = 1 if parity is enabled and S = 1 or 2.
- In 7-bit mode, i_data[7] is never transmitted and does not affect parity.
- Parity mode 11 behaves exactly like 00.
- o_tx is always driven from a flop; no combinational path from any input to o_tx.

Test Plan:
- Bench BAUD_DIV0=4, config 8N1 (par=00, d=1, s=0, bd=00), send 0x55 -> o_tx low 4 cycles starting one cycle after acceptance, then 1,0,1,0,1,0,1,0 for 4 cycles each, then high 4 cycles; o_tx_done pulses at cycle 41 after acceptance; frame length 40 cycles.
- Config 7E2 (par=01, d=0, s=1), send 0xC1 -> data bits 1,0,0,0,0,0,1, parity 0, two stop bits; bit 7 absent; frame length 11×DIV.
- Config 8O1 (par=10), send 0x00 -> parity bit 1. Config 8E1, send 0x07 -> parity bit 1. Config par=11 -> no parity bit.
- Pulse i_valid with 0xAA during a frame -> o_ready=0, no acceptance, current frame unchanged. Toggle i_bd_rate and i_d_num mid-frame -> current frame timing and length unchanged.
- Assert i_rst during DATA bit 3 -> at that edge o_tx=1, o_busy=0, o_ready=1, no o_tx_done pulse. The next send of 0x3C produces a correct full frame.
- Hold i_valid=1 with 0x12 then 0x34, 8N2, with BAUD_DIV3=3 and bd=11 -> two complete frames separated by exactly one idle-high cycle after the second stop bit; two o_tx_done pulses.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, 7/8 data bits (LSB first), optional parity and 1/2 stop bits.
// Frame configuration and baud divisor are captured at acceptance and held constant for the whole frame.
module uart_tx_frame #(
    parameter int DBITS     = 8,
    parameter int BAUD_DIV0 = 5208,
    parameter int BAUD_DIV1 = 2604,
    parameter int BAUD_DIV2 = 868,
    parameter int BAUD_DIV3 = 434
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [DBITS-1:0] i_data,
    input  logic [1:0]       i_par,
    input  logic             i_d_num,
    input  logic             i_s_num,
    input  logic [1:0]       i_bd_rate,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_tx_done
);

    localparam int CNT_W = $clog2(DBITS + 1);

    localparam logic [15:0] DIV0 = 16'(BAUD_DIV0);
    localparam logic [15:0] DIV1 = 16'(BAUD_DIV1);
    localparam logic [15:0] DIV2 = 16'(BAUD_DIV2);
    localparam logic [15:0] DIV3 = 16'(BAUD_DIV3);

    localparam logic [CNT_W-1:0] LAST_BIT_FULL  = CNT_W'(DBITS - 1);
    localparam logic [CNT_W-1:0] LAST_BIT_SHORT = CNT_W'(DBITS - 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_reg,   state_next;
    logic [15:0]       timer_reg,   timer_next;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [DBITS-1:0]  shift_reg,   shift_next;
    logic [15:0]       div_reg,     div_next;
    logic              par_en_reg,  par_en_next;
    logic              par_bit_reg, par_bit_next;
    logic              d_num_reg,   d_num_next;
    logic              s_num_reg,   s_num_next;
    logic              tx_reg,      tx_next;
    logic              done_reg,    done_next;

    logic [DBITS-1:0]  data_masked;
    logic [15:0]       div_sel;
    logic              bit_end;
    logic [CNT_W-1:0]  last_bit;
    logic [CNT_W-1:0]  last_stop;

    // In 7-bit mode the top data bit is dropped so it cannot leak into shifting or parity.
    genvar gi;
    generate
        for (gi = 0; gi < DBITS; gi++) begin : g_mask
            if (gi == DBITS - 1) begin : g_top
                assign data_masked[gi] = i_data[gi] & i_d_num;
            end else begin : g_low
                assign data_masked[gi] = i_data[gi];
            end
        end
    endgenerate

    always_comb begin
        div_sel = DIV0;
        case (i_bd_rate)
            2'b00:   div_sel = DIV0;
            2'b01:   div_sel = DIV1;
            2'b10:   div_sel = DIV2;
            default: div_sel = DIV3;
        endcase
    end

    assign bit_end   = (timer_reg == div_reg - 16'd1);
    assign last_bit  = d_num_reg ? LAST_BIT_FULL : LAST_BIT_SHORT;
    assign last_stop = {{(CNT_W-1){1'b0}}, s_num_reg};

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        div_next     = div_reg;
        par_en_next  = par_en_reg;
        par_bit_next = par_bit_reg;
        d_num_next   = d_num_reg;
        s_num_next   = s_num_reg;
        tx_next      = tx_reg;
        done_next    = 1'b0;

        if (state_reg != IDLE) begin
            timer_next = bit_end ? 16'd0 : timer_reg + 16'd1;
        end

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (i_valid) begin
                    state_next   = START;
                    timer_next   = 16'd0;
                    bit_cnt_next = '0;
                    shift_next   = data_masked;
                    div_next     = div_sel;
                    par_en_next  = (i_par == 2'b01) || (i_par == 2'b10);
                    par_bit_next = (^data_masked) ^ (i_par == 2'b10);
                    d_num_next   = i_d_num;
                    s_num_next   = i_s_num;
                    tx_next      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_reg == last_bit) begin
                        bit_cnt_next = '0;
                        if (par_en_reg) begin
                            state_next = PARITY;
                            tx_next    = par_bit_reg;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        // Bit 1 of the current word becomes bit 0 after this shift.
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_reg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    if (bit_cnt_reg == last_stop) begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                        done_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            timer_reg   <= 16'd0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            div_reg     <= DIV0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
            d_num_reg   <= 1'b1;
            s_num_reg   <= 1'b0;
            tx_reg      <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            div_reg     <= div_next;
            par_en_reg  <= par_en_next;
            par_bit_reg <= par_bit_next;
            d_num_reg   <= d_num_next;
            s_num_reg   <= s_num_next;
            tx_reg      <= tx_next;
            done_reg    <= done_next;
        end
    end

    assign o_ready   = (state_reg == IDLE);
    assign o_busy    = (state_reg != IDLE);
    assign o_tx      = tx_reg;
    assign o_tx_done = done_reg;

endmodule
